// File: rtl/load_fsm.sv
// Memory-load controller: Rj -> MAR, memory read, wait for MFC, MDR -> Ri.
// Bounded MFC wait aborts with err so a missing response cannot hang the CPU.
module load_fsm #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       MFC,
    input  logic [5:0] Ri,
    input  logic [5:0] Rj,
    output logic       R0_read,
    output logic       R1_read,
    output logic       R2_read,
    output logic       R3_read,
    output logic       P0_read,
    output logic       P1_read,
    output logic       R0_write,
    output logic       R1_write,
    output logic       R2_write,
    output logic       R3_write,
    output logic       P0_write,
    output logic       P1_write,
    output logic       MAR_write,
    output logic       MAR_mem_read,
    output logic       MEM_RW,
    output logic       MEM_EN,
    output logic       MDR_mem_write,
    output logic       MDR_read,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned NUM_REGS = 6;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_XFER = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      ri_q, rj_q, ri_nxt, rj_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  err_q, err_nxt;

    logic [NUM_REGS-1:0]   rd_q, wr_q, rd_nxt, wr_nxt;
    logic                  mar_write_q, mar_mem_read_q, mem_rw_q, mem_en_q;
    logic                  mdr_mem_write_q, mdr_read_q, done_q, err_out_q;
    logic                  mar_write_nxt, mar_mem_read_nxt, mem_rw_nxt, mem_en_nxt;
    logic                  mdr_mem_write_nxt, mdr_read_nxt, done_nxt, err_out_nxt;

    // Register index to one-hot strobe vector; indices above 5 select nothing.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Next-state, latched indices, wait counter and error flag.
    always_comb begin
        state_nxt = state;
        ri_nxt    = ri_q;
        rj_nxt    = rj_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ri_nxt = Ri;
                    rj_nxt = Rj;
                    if ((Ri > IDX_W'(NUM_REGS - 1)) || (Rj > IDX_W'(NUM_REGS - 1))) begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_ADDR;
                        err_nxt   = 1'b0;
                    end
                end
            end
            S_ADDR: state_nxt = S_REQ;
            S_REQ: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (MFC) begin
                    state_nxt = S_CAPT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_CAPT: state_nxt = S_XFER;
            S_XFER: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore decode of the upcoming state so strobes are registered yet aligned with it.
    always_comb begin
        rd_nxt            = '0;
        wr_nxt            = '0;
        mar_write_nxt     = 1'b0;
        mar_mem_read_nxt  = 1'b0;
        mem_rw_nxt        = 1'b0;
        mem_en_nxt        = 1'b0;
        mdr_mem_write_nxt = 1'b0;
        mdr_read_nxt      = 1'b0;
        done_nxt          = 1'b0;
        err_out_nxt       = 1'b0;
        case (state_nxt)
            S_ADDR: begin
                rd_nxt        = idx_onehot(rj_nxt);
                mar_write_nxt = 1'b1;
            end
            S_REQ, S_WAIT: begin
                mar_mem_read_nxt = 1'b1;
                mem_en_nxt       = 1'b1;
                mem_rw_nxt       = 1'b1;
            end
            S_CAPT: begin
                mar_mem_read_nxt  = 1'b1;
                mem_en_nxt        = 1'b1;
                mem_rw_nxt        = 1'b1;
                mdr_mem_write_nxt = 1'b1;
            end
            S_XFER: begin
                mdr_read_nxt = 1'b1;
                wr_nxt       = idx_onehot(ri_nxt);
            end
            S_DONE: begin
                done_nxt    = 1'b1;
                err_out_nxt = err_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            ri_q            <= '0;
            rj_q            <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            rd_q            <= '0;
            wr_q            <= '0;
            mar_write_q     <= 1'b0;
            mar_mem_read_q  <= 1'b0;
            mem_rw_q        <= 1'b0;
            mem_en_q        <= 1'b0;
            mdr_mem_write_q <= 1'b0;
            mdr_read_q      <= 1'b0;
            done_q          <= 1'b0;
            err_out_q       <= 1'b0;
        end else begin
            state           <= state_nxt;
            ri_q            <= ri_nxt;
            rj_q            <= rj_nxt;
            cnt_q           <= cnt_nxt;
            err_q           <= err_nxt;
            rd_q            <= rd_nxt;
            wr_q            <= wr_nxt;
            mar_write_q     <= mar_write_nxt;
            mar_mem_read_q  <= mar_mem_read_nxt;
            mem_rw_q        <= mem_rw_nxt;
            mem_en_q        <= mem_en_nxt;
            mdr_mem_write_q <= mdr_mem_write_nxt;
            mdr_read_q      <= mdr_read_nxt;
            done_q          <= done_nxt;
            err_out_q       <= err_out_nxt;
        end
    end

    assign R0_read       = rd_q[0];
    assign R1_read       = rd_q[1];
    assign R2_read       = rd_q[2];
    assign R3_read       = rd_q[3];
    assign P0_read       = rd_q[4];
    assign P1_read       = rd_q[5];
    assign R0_write      = wr_q[0];
    assign R1_write      = wr_q[1];
    assign R2_write      = wr_q[2];
    assign R3_write      = wr_q[3];
    assign P0_write      = wr_q[4];
    assign P1_write      = wr_q[5];
    assign MAR_write     = mar_write_q;
    assign MAR_mem_read  = mar_mem_read_q;
    assign MEM_RW        = mem_rw_q;
    assign MEM_EN        = mem_en_q;
    assign MDR_mem_write = mdr_mem_write_q;
    assign MDR_read      = mdr_read_q;
    assign done          = done_q;
    assign err           = err_out_q;

endmodule

// File: tb/tb_load_fsm.sv
// Vector bench for load_fsm: two instances (TIMEOUT 16 and 4) driven by the same stimulus.
module tb_load_fsm;

    logic       clk;
    logic       reset, start, mfc;
    logic [5:0] ri, rj;

    logic [5:0] rd16, wr16, rd4, wr4;
    logic [7:0] misc16, misc4;
    logic [19:0] obs16, obs4;

    assign obs16 = {rd16, wr16, misc16};
    assign obs4  = {rd4, wr4, misc4};

    // Observation layout: [19:14] reads, [13:8] writes, [7] MAR_write, [6] MAR_mem_read,
    // [5] MEM_RW, [4] MEM_EN, [3] MDR_mem_write, [2] MDR_read, [1] done, [0] err
    localparam logic [19:0] O_IDLE = 20'h00000;
    localparam logic [19:0] O_ADDR = 20'h00080;
    localparam logic [19:0] O_WAIT = 20'h00070;
    localparam logic [19:0] O_CAPT = 20'h00078;
    localparam logic [19:0] O_XFER = 20'h00004;
    localparam logic [19:0] O_DONE = 20'h00002;
    localparam logic [19:0] O_DERR = 20'h00003;

    load_fsm #(.TIMEOUT(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .MFC(mfc), .Ri(ri), .Rj(rj),
        .R0_read(rd16[0]), .R1_read(rd16[1]), .R2_read(rd16[2]),
        .R3_read(rd16[3]), .P0_read(rd16[4]), .P1_read(rd16[5]),
        .R0_write(wr16[0]), .R1_write(wr16[1]), .R2_write(wr16[2]),
        .R3_write(wr16[3]), .P0_write(wr16[4]), .P1_write(wr16[5]),
        .MAR_write(misc16[7]), .MAR_mem_read(misc16[6]), .MEM_RW(misc16[5]),
        .MEM_EN(misc16[4]), .MDR_mem_write(misc16[3]), .MDR_read(misc16[2]),
        .done(misc16[1]), .err(misc16[0])
    );

    load_fsm #(.TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .MFC(mfc), .Ri(ri), .Rj(rj),
        .R0_read(rd4[0]), .R1_read(rd4[1]), .R2_read(rd4[2]),
        .R3_read(rd4[3]), .P0_read(rd4[4]), .P1_read(rd4[5]),
        .R0_write(wr4[0]), .R1_write(wr4[1]), .R2_write(wr4[2]),
        .R3_write(wr4[3]), .P0_write(wr4[4]), .P1_write(wr4[5]),
        .MAR_write(misc4[7]), .MAR_mem_read(misc4[6]), .MEM_RW(misc4[5]),
        .MEM_EN(misc4[4]), .MDR_mem_write(misc4[3]), .MDR_read(misc4[2]),
        .done(misc4[1]), .err(misc4[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before an edge; e16/e4 are the outputs expected just after it.
    typedef struct {
        int          sc;
        logic        rst;
        logic        st;
        logic        m;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [19:0] e16;
        logic [19:0] e4;
    } vec_t;

    vec_t vecs[$];
    int   cur_sc;
    int   checks;
    int   errors;

    function automatic logic [19:0] rdb(input int i);
        return 20'(20'd1 << (14 + i));
    endfunction

    function automatic logic [19:0] wrb(input int i);
        return 20'(20'd1 << (8 + i));
    endfunction

    task automatic add(input logic r, input logic s, input logic m, input logic [5:0] a,
                       input logic [5:0] b, input logic [19:0] x16, input logic [19:0] x4);
        vec_t v;
        v.sc = cur_sc; v.rst = r; v.st = s; v.m = m; v.a = a; v.b = b;
        v.e16 = x16; v.e4 = x4;
        vecs.push_back(v);
    endtask

    task automatic add2(input logic r, input logic s, input logic m, input logic [5:0] a,
                        input logic [5:0] b, input logic [19:0] x);
        add(r, s, m, a, b, x, x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        int lat16, lat4;
        logic err16, err4, wrote;
        checks = 0;
        errors = 0;
        reset = 1'b0; start = 1'b0; mfc = 1'b0; ri = '0; rj = '0;

        // sc0: reset
        cur_sc = 0;
        add2(0, 0, 0, 0, 0, O_IDLE);
        add2(0, 1, 1, 2, 2, O_IDLE);
        add2(1, 0, 0, 0, 0, O_IDLE);

        // sc1: Ri=2 Rj=4, MFC on first WAIT cycle
        cur_sc = 1;
        add2(1, 1, 0, 2, 4, O_ADDR | rdb(4));
        add2(1, 0, 0, 2, 4, O_WAIT);
        add2(1, 0, 0, 2, 4, O_WAIT);
        add2(1, 0, 1, 2, 4, O_CAPT);
        add2(1, 0, 0, 2, 4, O_XFER | wrb(2));
        add2(1, 0, 0, 2, 4, O_DONE);
        add2(1, 0, 0, 2, 4, O_IDLE);

        // sc2: MFC in sixth WAIT cycle; TIMEOUT=4 instance aborts first
        cur_sc = 2;
        add2(1, 1, 0, 0, 1, O_ADDR | rdb(1));
        add2(1, 0, 0, 0, 1, O_WAIT);
        for (int c = 3; c <= 6; c++) add2(1, 0, 0, 0, 1, O_WAIT);
        add(1, 0, 0, 0, 1, O_WAIT, O_DERR);
        add(1, 0, 0, 0, 1, O_WAIT, O_IDLE);
        add(1, 0, 1, 0, 1, O_CAPT, O_IDLE);
        add(1, 0, 0, 0, 1, O_XFER | wrb(0), O_IDLE);
        add(1, 0, 0, 0, 1, O_DONE, O_IDLE);
        add2(1, 0, 0, 0, 1, O_IDLE);

        // sc3: MFC never arrives; both timeouts
        cur_sc = 3;
        add2(1, 1, 0, 3, 5, O_ADDR | rdb(5));
        add2(1, 0, 0, 3, 5, O_WAIT);
        for (int c = 3; c <= 6; c++) add2(1, 0, 0, 3, 5, O_WAIT);
        add(1, 0, 0, 3, 5, O_WAIT, O_DERR);
        for (int c = 8; c <= 18; c++) add(1, 0, 0, 3, 5, O_WAIT, O_IDLE);
        add(1, 0, 0, 3, 5, O_DERR, O_IDLE);
        add2(1, 0, 0, 3, 5, O_IDLE);

        // sc4: MFC exactly on the last allowed WAIT cycle of TIMEOUT=4
        cur_sc = 4;
        add2(1, 1, 0, 5, 0, O_ADDR | rdb(0));
        add2(1, 0, 0, 5, 0, O_WAIT);
        for (int c = 3; c <= 6; c++) add2(1, 0, 0, 5, 0, O_WAIT);
        add2(1, 0, 1, 5, 0, O_CAPT);
        add2(1, 0, 0, 5, 0, O_XFER | wrb(5));
        add2(1, 0, 0, 5, 0, O_DONE);
        add2(1, 0, 0, 5, 0, O_IDLE);

        // sc5: invalid indices
        cur_sc = 5;
        add2(1, 1, 0, 7, 0, O_DERR);
        add2(1, 0, 0, 7, 0, O_IDLE);
        add2(1, 1, 1, 0, 6, O_DERR);
        add2(1, 0, 1, 0, 6, O_IDLE);
        add2(1, 1, 0, 63, 63, O_DERR);
        add2(1, 0, 0, 63, 63, O_IDLE);

        // sc6: Ri=Rj=1, indices change after start
        cur_sc = 6;
        add2(1, 1, 0, 1, 1, O_ADDR | rdb(1));
        add2(1, 0, 0, 4, 2, O_WAIT);
        add2(1, 0, 0, 3, 0, O_WAIT);
        add2(1, 0, 1, 5, 3, O_CAPT);
        add2(1, 0, 0, 0, 4, O_XFER | wrb(1));
        add2(1, 0, 0, 2, 5, O_DONE);
        add2(1, 0, 0, 2, 5, O_IDLE);

        // sc7: start and MFC held high; MFC outside WAIT ignored, restart from IDLE
        cur_sc = 7;
        add2(1, 1, 1, 0, 0, O_ADDR | rdb(0));
        add2(1, 1, 1, 0, 0, O_WAIT);
        add2(1, 1, 1, 0, 0, O_WAIT);
        add2(1, 1, 1, 0, 0, O_CAPT);
        add2(1, 1, 1, 0, 0, O_XFER | wrb(0));
        add2(1, 1, 1, 0, 0, O_DONE);
        add2(1, 1, 1, 0, 0, O_IDLE);
        add2(1, 1, 1, 3, 3, O_ADDR | rdb(3));
        add2(1, 0, 1, 0, 0, O_WAIT);
        add2(1, 0, 1, 0, 0, O_WAIT);
        add2(1, 0, 1, 0, 0, O_CAPT);
        add2(1, 0, 1, 0, 0, O_XFER | wrb(3));
        add2(1, 0, 1, 0, 0, O_DONE);
        add2(1, 0, 0, 0, 0, O_IDLE);

        // sc8: reset during WAIT, then a clean load
        cur_sc = 8;
        add2(1, 1, 0, 2, 3, O_ADDR | rdb(3));
        add2(1, 0, 0, 2, 3, O_WAIT);
        add2(1, 0, 0, 2, 3, O_WAIT);
        add2(0, 0, 1, 2, 3, O_IDLE);
        add2(1, 0, 1, 2, 3, O_IDLE);
        add2(1, 0, 0, 2, 3, O_IDLE);
        add2(1, 1, 0, 4, 2, O_ADDR | rdb(2));
        add2(1, 0, 0, 4, 2, O_WAIT);
        add2(1, 0, 0, 4, 2, O_WAIT);
        add2(1, 0, 1, 4, 2, O_CAPT);
        add2(1, 0, 0, 4, 2, O_XFER | wrb(4));
        add2(1, 0, 0, 4, 2, O_DONE);
        add2(1, 0, 0, 4, 2, O_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; start = vecs[i].st; mfc = vecs[i].m;
            ri = vecs[i].a; rj = vecs[i].b;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sc%0d_t16", i, vecs[i].sc), 32'(obs16), 32'(vecs[i].e16));
            check($sformatf("vec%0d_sc%0d_t4", i, vecs[i].sc), 32'(obs4), 32'(vecs[i].e4));
        end

        // Hand-written: timeout latency measured with a bounded wait on done
        lat16 = 0; lat4 = 0; err16 = 1'b0; err4 = 1'b0; wrote = 1'b0;
        reset = 1'b1; start = 1'b1; mfc = 1'b0; ri = 6'd1; rj = 6'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if ((wr16 != 6'd0) || (wr4 != 6'd0) || misc16[3] || misc4[3]) wrote = 1'b1;
            if (misc16[1] && lat16 == 0) begin lat16 = c; err16 = misc16[0]; end
            if (misc4[1] && lat4 == 0) begin lat4 = c; err4 = misc4[0]; end
        end
        check("timeout_lat_t16", 32'(lat16), 32'd19);
        check("timeout_lat_t4", 32'(lat4), 32'd7);
        check("timeout_err_t16", 32'(err16), 32'd1);
        check("timeout_err_t4", 32'(err4), 32'd1);
        check("timeout_no_write", 32'(wrote), 32'd0);
        check("timeout_idle_after", 32'(obs16 | obs4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
